alu_issue_stage: RTL and testbench

//  ID->EX pipeline stage that produces the inputs consumed by alu.
//  - Decodes the RV32I integer-ALU instruction classes into a 4-bit alu_ctrl.
//  - Selects op1/op2 from the register-file data, PC and immediates.
//  - Registers the result behind a valid/ready handshake with stall and flush.

---
 rtl/alu_issue_stage.sv | 212 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   ID->EX pipeline register for the RV32I integer ALU. It decodes the
//   OP, OP-IMM, LUI and AUIPC classes into a 4-bit alu_ctrl. It selects the two
//   ALU operands from register-file data, the PC and the immediates. The result
//   is registered behind a valid/ready handshake that supports stall and flush.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      upstream instruction valid
//   in_ready   out  1      stage can accept this cycle
//   instr      in   32     instruction word
//   pc         in   WIDTH  instruction address
//   rs1_data   in   WIDTH  register-file read data, rs1
//   rs2_data   in   WIDTH  register-file read data, rs2
//   flush      in   1      kill held and incoming instruction
//   out_valid  out  1      registered outputs valid toward EX
//   out_ready  in   1      EX accepts this cycle
//   op1/op2    out  WIDTH  ALU operands
//   alu_ctrl   out  4      {alt, funct3}-style ALU operation code
//   rd         out  5      destination register
//   reg_write  out  1      write-back enable
//   illegal    out  1      instruction not in the supported classes
//
// Handshake
//   A transfer happens on a rising edge where valid && ready are both 1.
//   Upstream:   in_ready = !flush && (!out_valid || out_ready). The input is
//               taken when in_valid && in_ready.
//   Downstream: out_valid plus the data outputs stay constant while
//               out_valid && !out_ready. They change only after EX accepts the
//               instruction, or when a flush or reset occurs.
//   A flush empties the stage. It drops the held instruction and the
//   incoming one.
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SLL = 4'b0001;

  // Instruction fields
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [4:0]       w_rd;
  logic [WIDTH-1:0] w_imm_i;
  logic [WIDTH-1:0] w_imm_u;
  logic [WIDTH-1:0] w_shamt;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_imm_i  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign w_imm_u  = {instr[31:12], 12'b0};
  // Shift-immediates carry the funct7 selector in imm[11:5]. The ALU should
  // see only the shift amount, so SRAI by 3 gives op2 = 3 and not 0x403.
  assign w_shamt  = {{(WIDTH-5){1'b0}}, instr[24:20]};

  // Raw decode. These operands are before any legality gating.
  logic             w_legal;
  logic [3:0]       w_ctrl_raw;
  logic [WIDTH-1:0] w_op1_raw;
  logic [WIDTH-1:0] w_op2_raw;

  always_comb begin
    w_legal    = 1'b0;
    w_ctrl_raw = CTRL_ADD;
    w_op1_raw  = '0;
    w_op2_raw  = '0;
    unique case (w_opcode)
      OPC_OP: begin
        w_ctrl_raw = {instr[30], w_funct3};
        w_op1_raw  = rs1_data;
        w_op2_raw  = rs2_data;
        // The alternate funct7 encoding is valid only for SUB and SRA.
        w_legal    = (w_funct7 == F7_BASE) ||
                     ((w_funct7 == F7_ALT) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        w_op1_raw = rs1_data;
        unique case (w_funct3)
          3'b001: begin
            w_ctrl_raw = CTRL_SLL;
            w_op2_raw  = w_shamt;
            w_legal    = (w_funct7 == F7_BASE);
          end
          3'b101: begin
            w_ctrl_raw = {instr[30], 3'b101};
            w_op2_raw  = w_shamt;
            w_legal    = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          end
          default: begin
            // instr[30] belongs to the immediate in this case. ADDI must
            // therefore not decode as SUB.
            w_ctrl_raw = {1'b0, w_funct3};
            w_op2_raw  = w_imm_i;
            w_legal    = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        w_ctrl_raw = CTRL_ADD;
        w_op1_raw  = '0;
        w_op2_raw  = w_imm_u;
        w_legal    = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl_raw = CTRL_ADD;
        w_op1_raw  = pc;
        w_op2_raw  = w_imm_u;
        w_legal    = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // An illegal instruction still travels down the pipe so EX can raise the
  // trap. Its operands and control are forced to zero.
  logic [3:0]       w_ctrl;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic             w_reg_write;

  assign w_ctrl      = w_legal ? w_ctrl_raw : CTRL_ADD;
  assign w_op1       = w_legal ? w_op1_raw  : '0;
  assign w_op2       = w_legal ? w_op2_raw  : '0;
  assign w_reg_write = w_legal && (w_rd != 5'd0);

  // Handshake
  logic r_out_valid;
  logic w_load;

  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_load   = in_valid && in_ready;

  // Output register
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [3:0]       r_alu_ctrl;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_alu_ctrl  <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      // Flush takes priority over hold and load. Clearing reg_write as well
      // means a stale copy can never look like a pending write-back.
      r_out_valid <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_alu_ctrl  <= w_ctrl;
      r_rd        <= w_rd;
      r_reg_write <= w_reg_write;
      r_illegal   <= !w_legal;
    end else if (out_ready) begin
      // Drain: only valid drops. The data outputs keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign alu_ctrl  = r_alu_ctrl;
  assign rd        = r_rd;
  assign reg_write = r_reg_write;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed testbench for alu_issue_stage. Instruction words are built from
//   their fields. Expected operands and controls are hand-derived from the
//   RV32I encoding. Inputs change 1 ns after the rising edge, which is also
//   when the registered outputs are sampled.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int W = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [W-1:0]  pc;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [3:0]    alu_ctrl;
  logic [4:0]    rd;
  logic          reg_write;
  logic          illegal;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_ctrl  (alu_ctrl),
    .rd        (rd),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  // Encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2f,
                                        input logic [4:0] rs1f, input logic [2:0] f3,
                                        input logic [4:0] rdf);
    return {f7, rs2f, rs1f, f3, rdf, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1f,
                                        input logic [2:0] f3, input logic [4:0] rdf);
    return {imm, rs1f, f3, rdf, 7'b0010011};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i_w, input logic [W-1:0] p,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    instr    = i_w;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
  endtask

  // Issue one instruction with EX ready. The outputs are valid on return.
  task automatic issue(input logic [31:0] i_w, input logic [W-1:0] p,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    drive(i_w, p, a, b);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || op1 !== '0 || op2 !== '0 || alu_ctrl !== 4'd0 ||
        rd !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b op1=%h op2=%h ctrl=%b rd=%0d rw=%b ill=%b exp all 0",
               out_valid, op1, op2, alu_ctrl, rd, reg_write, illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sub();
    // SUB x3, x1, x2
    issue(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1000 || op1 !== 32'd5 || op2 !== 32'd7 ||
        rd !== 5'd3 || reg_write !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL sub got v=%b ctrl=%b op1=%h op2=%h rd=%0d rw=%b ill=%b exp 1 1000 5 7 3 1 0",
               out_valid, alu_ctrl, op1, op2, rd, reg_write, illegal);
    end
    tick();
    // Drain: valid drops, data keeps its last values
    checks++;
    if (out_valid !== 1'b0 || rd !== 5'd3 || op2 !== 32'd7) begin
      errors++;
      $display("FAIL drain got v=%b rd=%0d op2=%h exp 0 3 00000007", out_valid, rd, op2);
    end
  endtask

  task automatic test_imm();
    // SRAI x4, x1, 3. Only the shift amount matters to the ALU.
    issue(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd4), 32'h0, 32'h8000_0000, 32'h0);
    checks++;
    if (alu_ctrl !== 4'b1101 || op2[4:0] !== 5'd3 || op1 !== 32'h8000_0000 ||
        rd !== 5'd4 || reg_write !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL srai got ctrl=%b op2=%h op1=%h rd=%0d rw=%b ill=%b exp 1101 xx03 80000000 4 1 0",
               alu_ctrl, op2, op1, rd, reg_write, illegal);
    end
    // ADDI x5, x0, -1. The imm has bit 30 set, but it must not become SUB.
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd5), 32'h0, 32'h0, 32'h0);
    checks++;
    if (alu_ctrl !== 4'b0000 || op2 !== 32'hFFFF_FFFF || op1 !== 32'h0 || rd !== 5'd5 ||
        reg_write !== 1'b1) begin
      errors++;
      $display("FAIL addi got ctrl=%b op2=%h op1=%h rd=%0d rw=%b exp 0000 ffffffff 0 5 1",
               alu_ctrl, op2, op1, rd, reg_write);
    end
    // ORI x6, x2, 0x0F0
    issue(enc_i(12'h0F0, 5'd2, 3'b110, 5'd6), 32'h0, 32'h1234, 32'h0);
    checks++;
    if (alu_ctrl !== 4'b0110 || op2 !== 32'h0000_00F0 || op1 !== 32'h1234) begin
      errors++;
      $display("FAIL ori got ctrl=%b op2=%h op1=%h exp 0110 000000f0 00001234",
               alu_ctrl, op2, op1);
    end
    tick();
  endtask

  task automatic test_upper();
    // AUIPC x1, 0x12345 at pc 0x100
    issue({20'h12345, 5'd1, 7'b0010111}, 32'h100, 32'hDEAD, 32'hBEEF);
    checks++;
    if (op1 !== 32'h100 || op2 !== 32'h1234_5000 || alu_ctrl !== 4'b0000 ||
        rd !== 5'd1 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL auipc got op1=%h op2=%h ctrl=%b rd=%0d rw=%b exp 100 12345000 0000 1 1",
               op1, op2, alu_ctrl, rd, reg_write);
    end
    // LUI x7, 0xABCDE
    issue({20'hABCDE, 5'd7, 7'b0110111}, 32'h100, 32'hDEAD, 32'hBEEF);
    checks++;
    if (op1 !== 32'h0 || op2 !== 32'hABCD_E000 || alu_ctrl !== 4'b0000 || rd !== 5'd7) begin
      errors++;
      $display("FAIL lui got op1=%h op2=%h ctrl=%b rd=%0d exp 0 abcde000 0000 7",
               op1, op2, alu_ctrl, rd);
    end
    tick();
  endtask

  task automatic test_illegal();
    // The opcode 1111111 is not a supported class
    issue({25'h0000_0A0, 7'b1111111}, 32'h40, 32'h11, 32'h22);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0 ||
        alu_ctrl !== 4'b0000 || op1 !== 32'h0 || op2 !== 32'h0) begin
      errors++;
      $display("FAIL illegal_opcode got v=%b ill=%b rw=%b ctrl=%b op1=%h op2=%h exp 1 1 0 0000 0 0",
               out_valid, illegal, reg_write, alu_ctrl, op1, op2);
    end
    // R-type with alt funct7 on funct3=001 (no "SUB-SLL") is illegal
    issue(enc_r(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd9), 32'h0, 32'h11, 32'h22);
    checks++;
    if (illegal !== 1'b1 || reg_write !== 1'b0 || op1 !== 32'h0 || alu_ctrl !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_rfunct got ill=%b rw=%b op1=%h ctrl=%b exp 1 0 0 0000",
               illegal, reg_write, op1, alu_ctrl);
    end
    // SLLI with funct7=0100000 is illegal
    issue(enc_i({7'b0100000, 5'd2}, 5'd1, 3'b001, 5'd9), 32'h0, 32'h11, 32'h22);
    checks++;
    if (illegal !== 1'b1 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_slli got ill=%b rw=%b exp 1 0", illegal, reg_write);
    end
    // ADD x0, x1, x2 is legal but never writes
    issue(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'h0, 32'h11, 32'h22);
    checks++;
    if (illegal !== 1'b0 || reg_write !== 1'b0 || op1 !== 32'h11 || op2 !== 32'h22) begin
      errors++;
      $display("FAIL add_x0 got ill=%b rw=%b op1=%h op2=%h exp 0 0 11 22",
               illegal, reg_write, op1, op2);
    end
    tick();
  endtask

  task automatic test_stall_flush();
    logic [31:0] other;
    // SLT x8, x1, x2 is loaded while EX is stalled
    out_ready = 1'b0;
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd8), 32'h0, 32'hA, 32'hB);
    tick();
    // Offer a different instruction. It must not be taken.
    other = enc_i(12'h055, 5'd3, 3'b100, 5'd12);
    drive(other, 32'h0, 32'h99, 32'h98);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || alu_ctrl !== 4'b0010 || op1 !== 32'hA || op2 !== 32'hB ||
          rd !== 5'd8 || reg_write !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d got v=%b ctrl=%b op1=%h op2=%h rd=%0d rw=%b rdy=%b exp 1 0010 a b 8 1 0",
                 c, out_valid, alu_ctrl, op1, op2, rd, reg_write, in_ready);
      end
      tick();
    end
    // Flush while holding, with a valid input offered
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready got %b exp 0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL flush_out got v=%b rw=%b exp 0 0", out_valid, reg_write);
    end
    tick();
    // The dropped instruction (rd 12) must not appear
    checks++;
    if (out_valid !== 1'b0 || rd === 5'd12) begin
      errors++;
      $display("FAIL flush_drop got v=%b rd=%0d exp 0 and rd!=12", out_valid, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    out_ready = 1'b1;
    // ADDI x(k), x0, 10*k with rs1_data = 100*k. Expect {rd, op2[15:0], op1[10:0]}.
    for (int k = 1; k <= 4; k++) begin
      drive(enc_i(12'(10 * k), 5'd0, 3'b000, 5'(k)), 32'h0, 32'(100 * k), 32'h0);
      exp_q.push_back({5'(k), 16'(10 * k), 11'(100 * k)});
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d got %b exp 1", k, in_ready);
      end
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {rd, op2[15:0], op1[10:0]} !== exp) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b fields=%h exp v=1 fields=%h",
                 k, out_valid, {rd, op2[15:0], op1[10:0]}, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || rd !== 5'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got v=%b rd=%0d q=%0d exp 0 4 0", out_valid, rd, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0;
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b111, 5'd10), 32'h0, 32'hF0, 32'h0F);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_hold got v=%b rdy=%b exp 1 0", out_valid, in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op1 !== '0 || op2 !== '0 || alu_ctrl !== 4'd0 ||
        rd !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold got v=%b op1=%h op2=%h ctrl=%b rd=%0d rw=%b ill=%b rdy=%b exp 0s rdy=1",
               out_valid, op1, op2, alu_ctrl, rd, reg_write, illegal, in_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_sub();
    test_imm();
    test_upper();
    test_illegal();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
